fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the next-generation RV32 datapaths (multicycle and pipelined), replacing the inline PC register / PC mux.
- Owns the fetch PC.
- Issues requests on the instruction bus with a request/acknowledge handshake and at most one request outstanding.
- Buffers returned words with their PCs in a DEPTH-entry prefetch queue.
- Hands instructions to decode through a valid/ready handshake.
- Flushes and redirects on branch/jump or exception.

---
 rtl/fetch_prefetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// RV32 fetch stage: owns the PC, one outstanding bus request, DEPTH-entry prefetch queue.
// Latency: accept-to-oInstValid = bus latency + 1; fetch stalls when queue + outstanding would exceed DEPTH.
module fetch_prefetch_unit #(
   parameter int              XLEN       = 32,
   parameter int              DEPTH      = 4,
   parameter logic [XLEN-1:0] KTEXT_BASE = 32'h8000_0000
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic [XLEN-1:0]        iInitialPC,
   output logic                   oIReq,
   output logic [XLEN-1:0]        oIAddress,
   input  logic                   iIAck,
   input  logic                   iIValid,
   input  logic [XLEN-1:0]        iIReadData,
   output logic                   oInstValid,
   output logic [XLEN-1:0]        oInstr,
   output logic [XLEN-1:0]        oInstPC,
   input  logic                   iInstReady,
   input  logic                   iRedirect,
   input  logic [XLEN-1:0]        iRedirectPC,
   input  logic                   iExcOccurred,
   output logic                   oMisaligned,
   output logic [$clog2(DEPTH):0] oQueueCount
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            discard_q, discard_d;
   logic            mis_q, mis_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   count_after;
   logic [XLEN-1:0] mem_pc  [DEPTH];
   logic [XLEN-1:0] mem_ins [DEPTH];

   logic flush, rsp, push, pop, room, accept;

   always_comb begin
      flush       = iRedirect | iExcOccurred;
      rsp         = (state_q == S_WAIT) & iIValid;
      push        = rsp & ~discard_q & ~flush;
      pop         = (count_q != '0) & iInstReady & ~flush;
      count_after = count_q + CW'(push) - CW'(pop);

      // A new request must reserve a slot for its own response.
      room = 1'b0;
      if (state_q == S_IDLE) begin
         room = (count_q < DEPTH_C);
      end else begin
         room = rsp & (count_after < DEPTH_C);
      end
      oIReq  = ~flush & room;
      accept = oIReq & iIAck;

      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      discard_d = discard_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_after;
      mis_d     = iRedirect & ~iExcOccurred & (iRedirectPC[1:0] != 2'b00);

      if (flush) begin
         pc_d     = iExcOccurred ? KTEXT_BASE : {iRedirectPC[XLEN-1:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         // An in-flight response still has to be absorbed and thrown away.
         if ((state_q == S_WAIT) && !iIValid) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
         end else begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
         end
      end else begin
         if (rsp) begin
            discard_d = 1'b0;
            state_d   = accept ? S_WAIT : S_IDLE;
         end else if ((state_q == S_IDLE) && accept) begin
            state_d = S_WAIT;
         end
         if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
         end
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= S_IDLE;
         pc_q      <= iInitialPC;
         req_pc_q  <= '0;
         discard_q <= 1'b0;
         mis_q     <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         discard_q <= discard_d;
         mis_q     <= mis_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge iCLK) begin
      if (push && !iRST) begin
         mem_pc[wr_ptr_q]  <= req_pc_q;
         mem_ins[wr_ptr_q] <= iIReadData;
      end
   end

   assign oIAddress   = pc_q;
   assign oInstValid  = (count_q != '0);
   assign oInstr      = mem_ins[rd_ptr_q];
   assign oInstPC     = mem_pc[rd_ptr_q];
   assign oMisaligned = mis_q;
   assign oQueueCount = count_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: a bus model answers fetches with mem_word(addr); expected instructions are
// queued per accepted response of the current flush epoch and popped by the monitor on each consume.
`timescale 1ns/1ps
module tb_fetch_prefetch_unit;

   localparam int          DEPTH   = 4;
   localparam logic [31:0] INIT_PC = 32'h0040_0000;
   localparam logic [31:0] KTEXT   = 32'h8000_0000;

   logic        iCLK = 1'b0;
   logic        iRST, oIReq, iIAck, iIValid, oInstValid, iInstReady;
   logic        iRedirect, iExcOccurred, oMisaligned;
   logic [31:0] iInitialPC, oIAddress, iIReadData, oInstr, oInstPC, iRedirectPC;
   logic [2:0]  oQueueCount;

   always #5 iCLK = ~iCLK;

   fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .KTEXT_BASE(KTEXT)) dut (
      .iCLK(iCLK), .iRST(iRST), .iInitialPC(iInitialPC),
      .oIReq(oIReq), .oIAddress(oIAddress), .iIAck(iIAck),
      .iIValid(iIValid), .iIReadData(iIReadData),
      .oInstValid(oInstValid), .oInstr(oInstr), .oInstPC(oInstPC), .iInstReady(iInstReady),
      .iRedirect(iRedirect), .iRedirectPC(iRedirectPC), .iExcOccurred(iExcOccurred),
      .oMisaligned(oMisaligned), .oQueueCount(oQueueCount)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] acc_log[$];
   int          n_chk = 0;
   int          n_fail = 0;

   // monitor-owned model state
   bit          chk_en = 1'b0;
   int          epoch = 0;
   bit          acc_evt = 1'b0;
   logic [31:0] acc_addr;
   int          acc_epoch = 0;
   logic [31:0] exp_fetch = INIT_PC;
   bit          hold_exp = 1'b0;
   logic [31:0] hold_addr;
   bit          mis_exp = 1'b0;
   int          mis_cnt = 0;
   int          cons_since = 0;
   logic [31:0] first_pc;

   // driver-owned bus model state
   bit          bus_busy = 1'b0;
   int          bus_delay = 0;
   logic [31:0] bus_addr;
   int          bus_tag = 0;
   int          rsp_tag = -1;
   logic [31:0] rsp_addr;
   int          lat_min = 1;
   int          lat_max = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_first_acc(input string name, input logic [31:0] exp);
      if (acc_log.size() == 0) chk({name, "_seen"}, 32'd0, 32'd1);
      else                     chk(name, acc_log[0], exp);
   endtask

   task automatic chk_first_pc(input string name, input logic [31:0] exp);
      if (cons_since == 0) chk({name, "_seen"}, 32'd0, 32'd1);
      else                 chk(name, first_pc, exp);
   endtask

   // One cycle of stimulus, driven just after the falling edge.
   task automatic step(input bit rdy, input bit ack, input bit redir, input bit exc,
                       input logic [31:0] tgt, input bit rst);
      @(negedge iCLK);
      if (acc_evt) begin
         chk("one_outstanding", 32'(bus_busy), 32'd0);
         bus_busy  = 1'b1;
         bus_addr  = acc_addr;
         bus_tag   = acc_epoch;
         bus_delay = int'($urandom_range(lat_max, lat_min));
      end
      iIValid    = 1'b0;
      iIReadData = $urandom;
      rsp_tag    = -1;
      if (bus_busy) begin
         bus_delay--;
         if (bus_delay <= 0) begin
            iIValid    = 1'b1;
            iIReadData = mem_word(bus_addr);
            rsp_addr   = bus_addr;
            rsp_tag    = bus_tag;
            bus_busy   = 1'b0;
         end
      end
      if (rst) bus_busy = 1'b0;
      iInstReady   = rdy;
      iIAck        = ack;
      iRedirect    = redir;
      iExcOccurred = exc;
      iRedirectPC  = tgt;
      iRST         = rst;
   endtask

   task automatic wait_acc(input bit rdy, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step(rdy, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
         #3;
         ok = acc_evt;
      end
   endtask

   // Monitor: samples everything mid-cycle, after the driver has settled inputs.
   initial begin : monitor
      bit flush, acc, cons;
      forever begin
         @(negedge iCLK);
         #2;
         flush = iRedirect || iExcOccurred;
         acc   = oIReq && iIAck && !iRST;
         cons  = oInstValid && iInstReady && !flush && !iRST;
         if (chk_en) begin
            chk("queue_count", 32'(oQueueCount), 32'(exp_q.size()));
            chk("inst_valid", 32'(oInstValid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               chk("inst_pc", oInstPC, exp_q[0].pc);
               chk("instr", oInstr, exp_q[0].ins);
            end
            chk("misaligned", 32'(oMisaligned), 32'(mis_exp));
            if (flush) chk("req_in_flush", 32'(oIReq), 32'd0);
            if (hold_exp && oIReq && !flush && !iRST) chk("addr_hold", oIAddress, hold_addr);
            if (acc) chk("fetch_addr", oIAddress, exp_fetch);
         end
         acc_evt = acc;
         if (acc) begin
            acc_addr  = oIAddress;
            acc_epoch = epoch;
            acc_log.push_back(oIAddress);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (cons && exp_q.size() != 0) begin
            if (cons_since == 0) first_pc = oInstPC;
            void'(exp_q.pop_front());
            cons_since++;
         end
         if (chk_en && oMisaligned === 1'b1) mis_cnt++;
         hold_exp  = oIReq && !iIAck && !flush && !iRST;
         hold_addr = oIAddress;
         mis_exp   = iRedirect && !iExcOccurred && (iRedirectPC[1:0] != 2'b00) && !iRST;
         if (iRST) begin
            exp_q.delete();
            acc_log.delete();
            exp_fetch  = iInitialPC;
            cons_since = 0;
            epoch++;
            chk_en = 1'b1;
         end else if (flush) begin
            exp_q.delete();
            acc_log.delete();
            exp_fetch  = iExcOccurred ? KTEXT : {iRedirectPC[31:2], 2'b00};
            cons_since = 0;
            epoch++;
         end else if (iIValid && rsp_tag == epoch) begin
            exp_q.push_back('{rsp_addr, mem_word(rsp_addr)});
            if (chk_en) chk("no_overflow", 32'(exp_q.size() <= DEPTH), 32'd1);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      bit ok;
      int m0;
      int r;
      iRST = 1'b1; iIAck = 1'b0; iIValid = 1'b0; iIReadData = '0; iInstReady = 1'b0;
      iRedirect = 1'b0; iExcOccurred = 1'b0; iRedirectPC = '0; iInitialPC = INIT_PC;

      // reset state
      step(1, 1, 0, 0, 32'd0, 1);
      step(1, 1, 0, 0, 32'd0, 1);
      step(1, 1, 0, 0, 32'd0, 0);
      #1;
      chk("rst_inst_valid", 32'(oInstValid), 32'd0);
      chk("rst_count", 32'(oQueueCount), 32'd0);
      chk("rst_misaligned", 32'(oMisaligned), 32'd0);
      chk("rst_req", 32'(oIReq), 32'd1);
      chk("rst_addr", oIAddress, INIT_PC);

      // sequential fetch, 1-cycle bus
      repeat (8) step(1, 1, 0, 0, 32'd0, 0);
      #3;
      chk("seq_accepts", 32'(acc_log.size() >= 3), 32'd1);
      if (acc_log.size() >= 3) begin
         chk("seq_addr0", acc_log[0], 32'h0040_0000);
         chk("seq_addr1", acc_log[1], 32'h0040_0004);
         chk("seq_addr2", acc_log[2], 32'h0040_0008);
      end
      chk_first_pc("seq_first_pc", 32'h0040_0000);

      // fill with decode stalled, then release one slot
      step(0, 1, 1, 0, 32'h0040_0200, 0);
      repeat (15) step(0, 1, 0, 0, 32'd0, 0);
      #1;
      chk("full_count", 32'(oQueueCount), 32'd4);
      chk("full_req", 32'(oIReq), 32'd0);
      #2;
      chk("full_accepts", 32'(acc_log.size()), 32'd4);
      step(1, 1, 0, 0, 32'd0, 0);
      step(0, 1, 0, 0, 32'd0, 0);
      #1;
      chk("pop_count", 32'(oQueueCount), 32'd3);
      chk("pop_req", 32'(oIReq), 32'd1);
      repeat (4) step(0, 1, 0, 0, 32'd0, 0);
      #3;
      chk("refill_accepts", 32'(acc_log.size()), 32'd5);
      chk("refill_count", 32'(oQueueCount), 32'd4);

      // redirect while a 3-cycle response is in flight
      lat_min = 3; lat_max = 3;
      step(1, 1, 1, 0, 32'h0040_0300, 0);
      wait_acc(1'b1, ok);
      chk("stale_setup", 32'(ok), 32'd1);
      step(1, 1, 1, 0, 32'h0040_0100, 0);
      repeat (12) step(1, 1, 0, 0, 32'd0, 0);
      #3;
      chk_first_acc("redir_first_fetch", 32'h0040_0100);
      chk_first_pc("redir_first_pc", 32'h0040_0100);

      // exception wins over redirect
      lat_min = 1; lat_max = 1;
      m0 = mis_cnt;
      step(1, 1, 1, 1, 32'h0040_0102, 0);
      repeat (6) step(1, 1, 0, 0, 32'd0, 0);
      #3;
      chk_first_acc("exc_vector", KTEXT);
      chk("exc_no_misaligned", 32'(mis_cnt - m0), 32'd0);

      // misaligned redirect target
      m0 = mis_cnt;
      step(1, 1, 1, 0, 32'h0040_0102, 0);
      repeat (6) step(1, 1, 0, 0, 32'd0, 0);
      #3;
      chk_first_acc("misaligned_fetch", 32'h0040_0100);
      chk_first_pc("misaligned_first_pc", 32'h0040_0100);
      chk("misaligned_pulses", 32'(mis_cnt - m0), 32'd1);

      // reset during WAIT with a response in the reset cycle
      lat_min = 2; lat_max = 2;
      step(0, 1, 1, 0, 32'h0040_0400, 0);
      wait_acc(1'b0, ok);
      chk("rstwait_setup1", 32'(ok), 32'd1);
      wait_acc(1'b0, ok);
      chk("rstwait_setup2", 32'(ok), 32'd1);
      step(0, 1, 0, 0, 32'd0, 0);
      step(0, 1, 0, 0, 32'd0, 1);
      #1;
      chk("pre_rst_valid", 32'(oInstValid), 32'd1);
      step(1, 1, 0, 0, 32'd0, 0);
      #1;
      chk("post_rst_valid", 32'(oInstValid), 32'd0);
      chk("post_rst_count", 32'(oQueueCount), 32'd0);
      chk("post_rst_req", 32'(oIReq), 32'd1);
      chk("post_rst_addr", oIAddress, INIT_PC);
      repeat (6) step(1, 1, 0, 0, 32'd0, 0);
      #3;
      chk_first_acc("post_rst_fetch", INIT_PC);

      // randomized traffic
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(999, 0));
         step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
              (r >= 5) && (r < 40), r < 15,
              32'h0040_0000 | ($urandom & 32'h0000_0FFF), r >= 997);
      end
      repeat (4) step(1, 1, 0, 0, 32'd0, 0);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
